// File: rtl/xor_frame_checker_if.sv
// Handshake bundle for the XOR frame checker: input beat channel plus result channel.
interface xor_frame_checker_if #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic [WIDTH-1:0] exp_parity;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_parity;
    logic             out_err;
    logic             out_ovf;
    logic [LW-1:0]    out_len;

    // Source/sink side (data producer and result consumer)
    modport master (
        output in_valid, in_data, in_last, exp_parity, out_ready,
        input  in_ready, out_valid, out_parity, out_err, out_ovf, out_len
    );

    // Checker side
    modport slave (
        input  in_valid, in_data, in_last, exp_parity, out_ready,
        output in_ready, out_valid, out_parity, out_err, out_ovf, out_len
    );
endinterface

// File: rtl/xor_frame_checker.sv
// Streaming XOR-parity checker: folds every accepted word of a frame into a
// running XOR, then on the closing beat reports parity, length, mismatch and
// overflow. One result is held at a time; input stalls until it is taken.
module xor_frame_checker #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16
) (
    input logic                clk,
    input logic                rst,
    xor_frame_checker_if.slave bus
);
    localparam int LW = $clog2(MAX_LEN + 1);

    typedef enum logic {ACC, RES} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc;
    logic [LW-1:0]    cnt;
    logic [WIDTH-1:0] parity;
    logic             err;
    logic             ovf;
    logic [LW-1:0]    len;

    logic             accept;
    logic             close;
    logic [WIDTH-1:0] acc_n;
    logic [LW-1:0]    cnt_inc;

    // Beat folding and close detection; a frame hitting MAX_LEN closes even without in_last
    always_comb begin
        accept  = bus.in_valid & (state == ACC);
        acc_n   = acc ^ bus.in_data;
        cnt_inc = cnt + 1'b1;
        close   = accept & (bus.in_last | (cnt_inc == LW'(MAX_LEN)));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ACC;
        else     state <= state_n;
    end

    // Next state: ACC -> RES on close, RES -> ACC on result handshake (no bypass)
    always_comb begin
        state_n = state;
        case (state)
            ACC: if (close) state_n = RES;
            RES: if (bus.out_ready) state_n = ACC;
            default: state_n = ACC;
        endcase
    end

    // Accumulator, beat counter and result capture; result fields persist after handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            cnt    <= '0;
            parity <= '0;
            err    <= 1'b0;
            ovf    <= 1'b0;
            len    <= '0;
        end else if (accept) begin
            if (close) begin
                parity <= acc_n;
                len    <= cnt_inc;
                ovf    <= ~bus.in_last;
                err    <= ~bus.in_last | (acc_n != bus.exp_parity);
                acc    <= '0;
                cnt    <= '0;
            end else begin
                acc <= acc_n;
                cnt <= cnt_inc;
            end
        end
    end

    // Handshake flags come straight from the state register (no out_ready -> in_ready path)
    assign bus.in_ready   = (state == ACC);
    assign bus.out_valid  = (state == RES);
    assign bus.out_parity = parity;
    assign bus.out_err    = err;
    assign bus.out_ovf    = ovf;
    assign bus.out_len    = len;
endmodule
